// File: rtl/reservation_station.sv
// reservation_station: ALU issue buffer with CDB wakeup, same-edge dispatch bypass and one issue per cycle.
// Define RS_AGE_SELECT_EN to issue the oldest ready entry; otherwise the lowest-index ready entry issues.
module reservation_station #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_WIDTH = 4,
  parameter int OP_WIDTH  = 6
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clr_in,
  input  logic                 dsp_valid,
  input  logic [OP_WIDTH-1:0]  dsp_op,
  input  logic [31:0]          dsp_rs1_val,
  input  logic [31:0]          dsp_rs2_val,
  input  logic                 dsp_rs1_rdy,
  input  logic                 dsp_rs2_rdy,
  input  logic [ROB_WIDTH-1:0] dsp_rs1_tag,
  input  logic [ROB_WIDTH-1:0] dsp_rs2_tag,
  input  logic [ROB_WIDTH-1:0] dsp_rob_index,
  input  logic [31:0]          dsp_PC,
  input  logic [31:0]          dsp_imm,
  output logic                 rs_full,
  input  logic                 alu_ready,
  input  logic [ROB_WIDTH-1:0] alu_rob_index,
  input  logic [31:0]          alu_result,
  input  logic                 lsb_ready,
  input  logic [ROB_WIDTH-1:0] lsb_rob_index,
  input  logic [31:0]          lsb_result,
  output logic                 rs_to_alu_ready,
  output logic [OP_WIDTH-1:0]  rs_to_alu_op,
  output logic [31:0]          rs_to_alu_rs1,
  output logic [31:0]          rs_to_alu_rs2,
  output logic [ROB_WIDTH-1:0] rs_to_alu_rob_index,
  output logic [31:0]          rs_to_alu_PC,
  output logic [31:0]          rs_to_alu_imm
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]   busy;
  logic [RS_SIZE-1:0]   rj;
  logic [RS_SIZE-1:0]   rk;
  logic [OP_WIDTH-1:0]  op_q  [RS_SIZE];
  logic [31:0]          vj_q  [RS_SIZE];
  logic [31:0]          vk_q  [RS_SIZE];
  logic [31:0]          pc_q  [RS_SIZE];
  logic [31:0]          imm_q [RS_SIZE];
  logic [ROB_WIDTH-1:0] qj_q  [RS_SIZE];
  logic [ROB_WIDTH-1:0] qk_q  [RS_SIZE];
  logic [ROB_WIDTH-1:0] rob_q [RS_SIZE];

  logic [RS_SIZE-1:0] eligible;
  logic [RS_SIZE-1:0] busy_nxt;
  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   free_idx;
  logic               dsp_fire;
  logic               dj_rdy;
  logic               dk_rdy;
  logic [31:0]        dj_val;
  logic [31:0]        dk_val;

  assign rs_full  = &busy;
  assign eligible = busy & rj & rk;
  assign dsp_fire = dsp_valid && !rs_full;

  // Same-edge bypass for dispatched operands; the ALU bus takes precedence over the LSB bus.
  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    dj_rdy = dsp_rs1_rdy;
    dj_val = dsp_rs1_val;
    dk_rdy = dsp_rs2_rdy;
    dk_val = dsp_rs2_val;
    if (!dsp_rs1_rdy) begin
      if (alu_ready && alu_rob_index == dsp_rs1_tag) begin
        dj_rdy = 1'b1;
        dj_val = alu_result;
      end else if (lsb_ready && lsb_rob_index == dsp_rs1_tag) begin
        dj_rdy = 1'b1;
        dj_val = lsb_result;
      end
    end
    if (!dsp_rs2_rdy) begin
      if (alu_ready && alu_rob_index == dsp_rs2_tag) begin
        dk_rdy = 1'b1;
        dk_val = alu_result;
      end else if (lsb_ready && lsb_rob_index == dsp_rs2_tag) begin
        dk_rdy = 1'b1;
        dk_val = lsb_result;
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

`ifdef RS_AGE_SELECT_EN
  // older[i][j] set means entry j was dispatched before entry i.
  logic [RS_SIZE-1:0] older     [RS_SIZE];
  logic [RS_SIZE-1:0] older_nxt [RS_SIZE];

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (eligible[i] && ((older[i] & eligible) == '0)) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      older_nxt[i] = older[i];
    end
    if (dsp_fire) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        older_nxt[j][free_idx] = 1'b0;
      end
      older_nxt[free_idx] = busy;
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (rst_in || clr_in) older[i] <= '0;
      else if (rdy_in)      older[i] <= older_nxt[i];
    end
  end
`else
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    busy_nxt = busy;
    if (sel_valid) busy_nxt[sel_idx] = 1'b0;
    if (dsp_fire)  busy_nxt[free_idx] = 1'b1;
  end

  // NOTE: payload arrays carry no reset; busy gates every use of them, so only busy is cleared.
  always_ff @(posedge clk_in) begin
    if (!rst_in && !clr_in && rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (dsp_fire && free_idx == IDX_W'(i)) begin
          op_q[i]  <= dsp_op;
          vj_q[i]  <= dj_val;
          vk_q[i]  <= dk_val;
          rj[i]    <= dj_rdy;
          rk[i]    <= dk_rdy;
          qj_q[i]  <= dsp_rs1_tag;
          qk_q[i]  <= dsp_rs2_tag;
          rob_q[i] <= dsp_rob_index;
          pc_q[i]  <= dsp_PC;
          imm_q[i] <= dsp_imm;
        end else if (busy[i]) begin
          if (!rj[i]) begin
            if (alu_ready && alu_rob_index == qj_q[i]) begin
              vj_q[i] <= alu_result;
              rj[i]   <= 1'b1;
            end else if (lsb_ready && lsb_rob_index == qj_q[i]) begin
              vj_q[i] <= lsb_result;
              rj[i]   <= 1'b1;
            end
          end
          if (!rk[i]) begin
            if (alu_ready && alu_rob_index == qk_q[i]) begin
              vk_q[i] <= alu_result;
              rk[i]   <= 1'b1;
            end else if (lsb_ready && lsb_rob_index == qk_q[i]) begin
              vk_q[i] <= lsb_result;
              rk[i]   <= 1'b1;
            end
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy                <= '0;
      rs_to_alu_ready     <= 1'b0;
      rs_to_alu_op        <= '0;
      rs_to_alu_rs1       <= '0;
      rs_to_alu_rs2       <= '0;
      rs_to_alu_rob_index <= '0;
      rs_to_alu_PC        <= '0;
      rs_to_alu_imm       <= '0;
    end else if (clr_in) begin
      busy            <= '0;
      rs_to_alu_ready <= 1'b0;
    end else if (!rdy_in) begin
      rs_to_alu_ready <= 1'b0;
    end else begin
      busy            <= busy_nxt;
      rs_to_alu_ready <= sel_valid;
      if (sel_valid) begin
        rs_to_alu_op        <= op_q[sel_idx];
        rs_to_alu_rs1       <= vj_q[sel_idx];
        rs_to_alu_rs2       <= vk_q[sel_idx];
        rs_to_alu_rob_index <= rob_q[sel_idx];
        rs_to_alu_PC        <= pc_q[sel_idx];
        rs_to_alu_imm       <= imm_q[sel_idx];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios, a per-cycle reference model of the issue buffer,
// and literal expectations at the key points of each scenario.
module tb_reservation_station;

  localparam int N = 16;
  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_BEQ = 6'd10;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic        dsp_valid;
  logic [5:0]  dsp_op;
  logic [31:0] dsp_rs1_val, dsp_rs2_val;
  logic        dsp_rs1_rdy, dsp_rs2_rdy;
  logic [3:0]  dsp_rs1_tag, dsp_rs2_tag, dsp_rob_index;
  logic [31:0] dsp_PC, dsp_imm;
  logic        rs_full;
  logic        alu_ready, lsb_ready;
  logic [3:0]  alu_rob_index, lsb_rob_index;
  logic [31:0] alu_result, lsb_result;
  logic        rs_to_alu_ready;
  logic [5:0]  rs_to_alu_op;
  logic [31:0] rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_PC, rs_to_alu_imm;
  logic [3:0]  rs_to_alu_rob_index;

  reservation_station #(.RS_SIZE(N), .ROB_WIDTH(4), .OP_WIDTH(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .dsp_valid(dsp_valid), .dsp_op(dsp_op),
    .dsp_rs1_val(dsp_rs1_val), .dsp_rs2_val(dsp_rs2_val),
    .dsp_rs1_rdy(dsp_rs1_rdy), .dsp_rs2_rdy(dsp_rs2_rdy),
    .dsp_rs1_tag(dsp_rs1_tag), .dsp_rs2_tag(dsp_rs2_tag),
    .dsp_rob_index(dsp_rob_index), .dsp_PC(dsp_PC), .dsp_imm(dsp_imm),
    .rs_full(rs_full),
    .alu_ready(alu_ready), .alu_rob_index(alu_rob_index), .alu_result(alu_result),
    .lsb_ready(lsb_ready), .lsb_rob_index(lsb_rob_index), .lsb_result(lsb_result),
    .rs_to_alu_ready(rs_to_alu_ready), .rs_to_alu_op(rs_to_alu_op),
    .rs_to_alu_rs1(rs_to_alu_rs1), .rs_to_alu_rs2(rs_to_alu_rs2),
    .rs_to_alu_rob_index(rs_to_alu_rob_index), .rs_to_alu_PC(rs_to_alu_PC),
    .rs_to_alu_imm(rs_to_alu_imm)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a table of waiting micro-ops plus the expected issue register.
  typedef struct {
    bit         busy;
    bit         r1, r2;
    logic [5:0] op;
    logic [31:0] v1, v2, pc, imm;
    logic [3:0] q1, q2, rob;
    int         seq;
  } ent_t;

  ent_t        m [N];
  bit          model_on = 1'b0;
  int          seq_ctr  = 0;
  logic        exp_ready;
  logic [5:0]  exp_op;
  logic [31:0] exp_rs1, exp_rs2, exp_pc, exp_imm;
  logic [3:0]  exp_rob;

  function automatic bit bus_hit(input logic [3:0] tag, output logic [31:0] data);
    data = 32'd0;
    if (alu_ready && alu_rob_index == tag) begin
      data = alu_result;
      return 1'b1;
    end
    if (lsb_ready && lsb_rob_index == tag) begin
      data = lsb_result;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_edge();
    int pick, free_slot;
    bit full, hit;
    logic [31:0] d;
    ent_t e;
    if (rst_in) begin
      for (int i = 0; i < N; i++) m[i].busy = 1'b0;
      exp_ready = 1'b0; exp_op = '0; exp_rs1 = '0; exp_rs2 = '0;
      exp_rob = '0; exp_pc = '0; exp_imm = '0;
      model_on = 1'b1;
      return;
    end
    if (clr_in) begin
      for (int i = 0; i < N; i++) m[i].busy = 1'b0;
      exp_ready = 1'b0;
      return;
    end
    if (!rdy_in) begin
      exp_ready = 1'b0;
      return;
    end
    pick = -1;
    for (int i = 0; i < N; i++) begin
      if (m[i].busy && m[i].r1 && m[i].r2) begin
`ifdef RS_AGE_SELECT_EN
        if (pick < 0 || m[i].seq < m[pick].seq) pick = i;
`else
        if (pick < 0) pick = i;
`endif
      end
    end
    full = 1'b1;
    free_slot = -1;
    for (int i = 0; i < N; i++) begin
      if (!m[i].busy) begin
        full = 1'b0;
        if (free_slot < 0) free_slot = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].busy) begin
        if (!m[i].r1) begin
          hit = bus_hit(m[i].q1, d);
          if (hit) begin m[i].v1 = d; m[i].r1 = 1'b1; end
        end
        if (!m[i].r2) begin
          hit = bus_hit(m[i].q2, d);
          if (hit) begin m[i].v2 = d; m[i].r2 = 1'b1; end
        end
      end
    end
    if (dsp_valid && !full) begin
      e.busy = 1'b1; e.op = dsp_op; e.q1 = dsp_rs1_tag; e.q2 = dsp_rs2_tag;
      e.rob = dsp_rob_index; e.pc = dsp_PC; e.imm = dsp_imm; e.seq = seq_ctr++;
      e.r1 = dsp_rs1_rdy; e.v1 = dsp_rs1_val;
      e.r2 = dsp_rs2_rdy; e.v2 = dsp_rs2_val;
      if (!e.r1) begin
        hit = bus_hit(e.q1, d);
        if (hit) begin e.v1 = d; e.r1 = 1'b1; end
      end
      if (!e.r2) begin
        hit = bus_hit(e.q2, d);
        if (hit) begin e.v2 = d; e.r2 = 1'b1; end
      end
      m[free_slot] = e;
    end
    if (pick >= 0) begin
      exp_ready = 1'b1;
      exp_op = m[pick].op; exp_rs1 = m[pick].v1; exp_rs2 = m[pick].v2;
      exp_rob = m[pick].rob; exp_pc = m[pick].pc; exp_imm = m[pick].imm;
      m[pick].busy = 1'b0;
    end else begin
      exp_ready = 1'b0;
    end
  endtask

  always @(posedge clk_in) model_edge();

  always @(negedge clk_in) begin
    if (model_on) begin
      automatic bit exp_full = 1'b1;
      for (int i = 0; i < N; i++) if (!m[i].busy) exp_full = 1'b0;
      check("model_full",  {31'd0, rs_full},             {31'd0, exp_full});
      check("model_ready", {31'd0, rs_to_alu_ready},     {31'd0, exp_ready});
      check("model_op",    {26'd0, rs_to_alu_op},        {26'd0, exp_op});
      check("model_rs1",   rs_to_alu_rs1,                exp_rs1);
      check("model_rs2",   rs_to_alu_rs2,                exp_rs2);
      check("model_rob",   {28'd0, rs_to_alu_rob_index}, {28'd0, exp_rob});
      check("model_pc",    rs_to_alu_PC,                 exp_pc);
      check("model_imm",   rs_to_alu_imm,                exp_imm);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic quiet();
    dsp_valid = 1'b0; alu_ready = 1'b0; lsb_ready = 1'b0; clr_in = 1'b0;
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [31:0] v1, input logic r1,
                          input logic [3:0] t1, input logic [31:0] v2, input logic r2,
                          input logic [3:0] t2, input logic [3:0] rob);
    dsp_valid = 1'b1; dsp_op = op;
    dsp_rs1_val = v1; dsp_rs1_rdy = r1; dsp_rs1_tag = t1;
    dsp_rs2_val = v2; dsp_rs2_rdy = r2; dsp_rs2_tag = t2;
    dsp_rob_index = rob; dsp_PC = 32'h1000 + {28'd0, rob}; dsp_imm = 32'h20 + {28'd0, rob};
  endtask

  task automatic broadcast_alu(input logic [3:0] tag, input logic [31:0] data);
    alu_ready = 1'b1; alu_rob_index = tag; alu_result = data;
  endtask

  task automatic broadcast_lsb(input logic [3:0] tag, input logic [31:0] data);
    lsb_ready = 1'b1; lsb_rob_index = tag; lsb_result = data;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    quiet();
    dispatch(6'd0, 0, 1'b1, 4'd0, 0, 1'b1, 4'd0, 4'd0);
    dsp_valid = 1'b0;
    alu_rob_index = '0; alu_result = '0; lsb_rob_index = '0; lsb_result = '0;
    step(2);
    rst_in = 1'b0;
    check("reset_ready", {31'd0, rs_to_alu_ready}, 32'd0);
    check("reset_full",  {31'd0, rs_full}, 32'd0);
    check("reset_rs1",   rs_to_alu_rs1, 32'd0);
    check("reset_rob",   {28'd0, rs_to_alu_rob_index}, 32'd0);

    // ready operands: dispatch edge, then issue on the following edge
    dispatch(OP_ADD, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 4'd3);
    step(1); quiet();
    check("add_not_yet", {31'd0, rs_to_alu_ready}, 32'd0);
    step(1);
    check("add_ready", {31'd0, rs_to_alu_ready}, 32'd1);
    check("add_op",    {26'd0, rs_to_alu_op}, {26'd0, OP_ADD});
    check("add_rs1",   rs_to_alu_rs1, 32'd5);
    check("add_rs2",   rs_to_alu_rs2, 32'd7);
    check("add_rob",   {28'd0, rs_to_alu_rob_index}, 32'd3);
    step(1);
    check("add_done",  {31'd0, rs_to_alu_ready}, 32'd0);

    // wakeup through the ALU bus one cycle after dispatch
    dispatch(OP_BEQ, 32'd0, 1'b0, 4'd2, 32'd3, 1'b1, 4'd0, 4'd5);
    step(1); quiet();
    broadcast_alu(4'd2, 32'd9);
    step(1); quiet();
    check("beq_wake_edge", {31'd0, rs_to_alu_ready}, 32'd0);
    step(1);
    check("beq_ready", {31'd0, rs_to_alu_ready}, 32'd1);
    check("beq_rs1",   rs_to_alu_rs1, 32'd9);
    check("beq_rob",   {28'd0, rs_to_alu_rob_index}, 32'd5);

    // same-edge bypass from the LSB bus, then ALU priority when both buses match
    dispatch(OP_ADD, 32'd1, 1'b1, 4'd0, 32'd0, 1'b0, 4'd4, 4'd6);
    broadcast_lsb(4'd4, 32'h100);
    step(1); quiet();
    step(1);
    check("byp_ready", {31'd0, rs_to_alu_ready}, 32'd1);
    check("byp_rs2",   rs_to_alu_rs2, 32'h100);
    dispatch(OP_ADD, 32'd1, 1'b1, 4'd0, 32'd0, 1'b0, 4'd4, 4'd7);
    broadcast_alu(4'd4, 32'hAAA);
    broadcast_lsb(4'd4, 32'hBBB);
    step(1); quiet();
    step(1);
    check("prio_rs2", rs_to_alu_rs2, 32'hAAA);
    check("prio_rob", {28'd0, rs_to_alu_rob_index}, 32'd7);

    // fill all entries, drop a 17th request, free one entry via wakeup
    for (int i = 0; i < N; i++) begin
      dispatch(OP_ADD, 32'd0, 1'b0, 4'(i), 32'd1, 1'b1, 4'd0, 4'(i));
      step(1);
    end
    quiet();
    check("full_set", {31'd0, rs_full}, 32'd1);
    dispatch(OP_BEQ, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd15);
    step(1); quiet();
    check("full_drop", {31'd0, rs_to_alu_ready}, 32'd0);
    broadcast_alu(4'd7, 32'h77);
    step(1); quiet();
    check("full_still", {31'd0, rs_full}, 32'd1);
    step(1);
    check("full_issue_rob", {28'd0, rs_to_alu_rob_index}, 32'd7);
    check("full_issue_rs1", rs_to_alu_rs1, 32'h77);
    check("full_cleared",   {31'd0, rs_full}, 32'd0);
    clr_in = 1'b1;
    step(1); quiet();

    // flush while a wakeup is on the bus: nothing survives
    for (int i = 1; i <= 3; i++) begin
      dispatch(OP_ADD, 32'd0, 1'b0, 4'(i), 32'd2, 1'b1, 4'd0, 4'(i));
      step(1);
    end
    quiet();
    clr_in = 1'b1;
    broadcast_alu(4'd1, 32'h11);
    dispatch(OP_ADD, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd9);
    step(1); quiet();
    check("clr_ready", {31'd0, rs_to_alu_ready}, 32'd0);
    check("clr_full",  {31'd0, rs_full}, 32'd0);
    broadcast_alu(4'd2, 32'h22);
    step(1); quiet();
    broadcast_lsb(4'd3, 32'h33);
    step(1); quiet();
    step(2);
    check("clr_no_issue", {31'd0, rs_to_alu_ready}, 32'd0);

    // A waits in slot0, B ready in slot1, A woken while C dispatches into slot2
    dispatch(OP_ADD, 32'd0, 1'b0, 4'd6, 32'd4, 1'b1, 4'd0, 4'd10);
    step(1);
    dispatch(OP_ADD, 32'd2, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 4'd11);
    step(1);
    dispatch(OP_ADD, 32'd8, 1'b1, 4'd0, 32'd8, 1'b1, 4'd0, 4'd12);
    broadcast_alu(4'd6, 32'h66);
    step(1); quiet();
    check("order_first",  {28'd0, rs_to_alu_rob_index}, 32'd11);
    step(1);
    check("order_second", {28'd0, rs_to_alu_rob_index}, 32'd10);
    check("order_a_rs1",  rs_to_alu_rs1, 32'h66);
    step(1);
    check("order_third",  {28'd0, rs_to_alu_rob_index}, 32'd12);
    step(1);
    check("order_idle",   {31'd0, rs_to_alu_ready}, 32'd0);

    // global stall holds a ready entry for three edges
    dispatch(OP_BEQ, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd13);
    step(1); quiet();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stall_hold", {31'd0, rs_to_alu_ready}, 32'd0);
    end
    rdy_in = 1'b1;
    step(1);
    check("stall_release", {31'd0, rs_to_alu_ready}, 32'd1);
    check("stall_rob",     {28'd0, rs_to_alu_rob_index}, 32'd13);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
